// File: rtl/pe_mac_au.sv
// PE multiply-accumulate unit: signed ifmap x weight products summed into
// acclen-long partial sums. The multiply is gated off for zero operands.
module pe_mac_au #(
  parameter int DWd     = 16,
  parameter int PsumWd  = 36,
  parameter int ConfDWd = 4,
  parameter int CntWd   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_cont_start,
  input  logic                     i_cont_done,
  input  logic                     i_cont_stall,
  input  logic                     i_cont_reset,
  input  logic [ConfDWd-1:0]       i_cfg_acclen,
  input  logic                     i_ipix_valid,
  output logic                     o_ipix_ready,
  input  logic [DWd-1:0]           i_ipix_data,
  input  logic                     i_ipix_zero,
  input  logic                     i_wpix_valid,
  output logic                     o_wpix_ready,
  input  logic [DWd-1:0]           i_wpix_data,
  input  logic                     i_wpix_zero,
  output logic                     o_psum_valid,
  input  logic                     i_psum_ready,
  output logic [PsumWd-1:0]        o_psum_data,
  output logic                     o_done,
  output logic [CntWd-1:0]         o_skip_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                    state_q, state_d;
  logic [2:1]                vld_pipe_q, vld_pipe_d;
  logic signed [DWd-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic                      s1_zero_q, s1_zero_d, s1_last_q, s1_last_d;
  logic                      s2_last_q, s2_last_d;
  logic signed [2*DWd-1:0]   p2_q, p2_d;
  logic signed [PsumWd-1:0]  acc_q, acc_d, psum_q, psum_d;
  logic                      psum_vld_q, psum_vld_d;
  logic [ConfDWd-1:0]        acclen_q, acclen_d, grp_cnt_q, grp_cnt_d;
  logic [CntWd-1:0]          skip_q, skip_d;

  logic                      en, rdy, accept, zero, drain_emit, done_w;
  logic [ConfDWd-1:0]        last_idx;
  logic signed [PsumWd-1:0]  p2_ext, sum;

  always_comb begin
    en         = !i_cont_stall && !(psum_vld_q && !i_psum_ready);
    rdy        = (state_q == RUN) && en;
    accept     = rdy && i_ipix_valid && i_wpix_valid;
    zero       = i_ipix_zero | i_wpix_zero;
    // acclen of 0 wraps to an index of all-ones, i.e. a 2^ConfDWd group
    last_idx   = acclen_q - 1'b1;
    p2_ext     = {{(PsumWd-2*DWd){p2_q[2*DWd-1]}}, p2_q};
    sum        = acc_q + p2_ext;
    // a partial group left in acc once the pipe is empty goes out as a short psum
    drain_emit = (state_q == DRAIN) && en && (vld_pipe_q == '0) && (grp_cnt_q != '0);
    done_w     = (state_q == DRAIN) && !i_cont_stall && (vld_pipe_q == '0) &&
                 !psum_vld_q && (grp_cnt_q == '0);
  end

  always_comb begin
    state_d    = state_q;
    vld_pipe_d = vld_pipe_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    s1_zero_d  = s1_zero_q;
    s1_last_d  = s1_last_q;
    s2_last_d  = s2_last_q;
    p2_d       = p2_q;
    acc_d      = acc_q;
    psum_d     = psum_q;
    psum_vld_d = psum_vld_q;
    acclen_d   = acclen_q;
    grp_cnt_d  = grp_cnt_q;
    skip_d     = skip_q;

    if (!i_cont_stall) begin
      case (state_q)
        IDLE: if (i_cont_start) begin
          state_d   = RUN;
          acclen_d  = i_cfg_acclen;
          skip_d    = '0;
          grp_cnt_d = '0;
        end
        RUN:     if (i_cont_done) state_d = DRAIN;
        DRAIN:   if (done_w) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (en) begin
      vld_pipe_d = {vld_pipe_q[1], accept};
      s2_last_d  = s1_last_q;
      if (s1_zero_q) p2_d = '0;
      else           p2_d = op_a_q * op_b_q;

      if (accept) begin
        s1_zero_d = zero;
        s1_last_d = (grp_cnt_q == last_idx);
        grp_cnt_d = (grp_cnt_q == last_idx) ? '0 : grp_cnt_q + 1'b1;
        if (!zero) begin
          op_a_d = signed'(i_ipix_data);
          op_b_d = signed'(i_wpix_data);
        end else if (skip_q != '1) begin
          skip_d = skip_q + 1'b1;
        end
      end

      if (psum_vld_q && i_psum_ready) psum_vld_d = 1'b0;

      if (vld_pipe_q[2]) begin
        if (s2_last_q) begin
          psum_d     = sum;
          psum_vld_d = 1'b1;
          acc_d      = '0;
        end else begin
          acc_d      = sum;
        end
      end else if (drain_emit) begin
        psum_d     = acc_q;
        psum_vld_d = 1'b1;
        acc_d      = '0;
        grp_cnt_d  = '0;
      end
    end

    if (i_cont_reset) begin
      state_d    = IDLE;
      vld_pipe_d = '0;
      op_a_d     = '0;
      op_b_d     = '0;
      s1_zero_d  = 1'b0;
      s1_last_d  = 1'b0;
      s2_last_d  = 1'b0;
      p2_d       = '0;
      acc_d      = '0;
      psum_d     = '0;
      psum_vld_d = 1'b0;
      acclen_d   = '0;
      grp_cnt_d  = '0;
      skip_d     = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      vld_pipe_q <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      s1_zero_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      p2_q       <= '0;
      acc_q      <= '0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      acclen_q   <= '0;
      grp_cnt_q  <= '0;
      skip_q     <= '0;
    end else begin
      state_q    <= state_d;
      vld_pipe_q <= vld_pipe_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      s1_zero_q  <= s1_zero_d;
      s1_last_q  <= s1_last_d;
      s2_last_q  <= s2_last_d;
      p2_q       <= p2_d;
      acc_q      <= acc_d;
      psum_q     <= psum_d;
      psum_vld_q <= psum_vld_d;
      acclen_q   <= acclen_d;
      grp_cnt_q  <= grp_cnt_d;
      skip_q     <= skip_d;
    end
  end

  assign o_ipix_ready = rdy;
  assign o_wpix_ready = rdy;
  assign o_psum_valid = psum_vld_q;
  assign o_psum_data  = psum_q;
  assign o_done       = done_w && !i_cont_reset;
  assign o_skip_cnt   = skip_q;

endmodule

// File: tb/tb_pe_mac_au.sv
// Scoreboard bench for pe_mac_au: directed groups push expected psums,
// a negedge monitor pops and compares on each psum handshake.
module tb_pe_mac_au;
  localparam int DWd = 16, PsumWd = 36, ConfDWd = 4, CntWd = 16;

  logic i_clk = 1'b0, i_rstn = 1'b0;
  logic i_cont_start = 0, i_cont_done = 0, i_cont_stall = 0, i_cont_reset = 0;
  logic [ConfDWd-1:0] i_cfg_acclen = '0;
  logic i_ipix_valid = 0, i_ipix_zero = 0, i_wpix_valid = 0, i_wpix_zero = 0;
  logic [DWd-1:0] i_ipix_data = '0, i_wpix_data = '0;
  logic i_psum_ready = 1'b1;
  logic o_ipix_ready, o_wpix_ready, o_psum_valid, o_done;
  logic [PsumWd-1:0] o_psum_data;
  logic [CntWd-1:0] o_skip_cnt;

  pe_mac_au #(.DWd(DWd), .PsumWd(PsumWd), .ConfDWd(ConfDWd), .CntWd(CntWd)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_cont_start(i_cont_start), .i_cont_done(i_cont_done),
    .i_cont_stall(i_cont_stall), .i_cont_reset(i_cont_reset),
    .i_cfg_acclen(i_cfg_acclen),
    .i_ipix_valid(i_ipix_valid), .o_ipix_ready(o_ipix_ready),
    .i_ipix_data(i_ipix_data), .i_ipix_zero(i_ipix_zero),
    .i_wpix_valid(i_wpix_valid), .o_wpix_ready(o_wpix_ready),
    .i_wpix_data(i_wpix_data), .i_wpix_zero(i_wpix_zero),
    .o_psum_valid(o_psum_valid), .i_psum_ready(i_psum_ready),
    .o_psum_data(o_psum_data), .o_done(o_done), .o_skip_cnt(o_skip_cnt)
  );

  always #5 i_clk = ~i_clk;

  longint exp_q[$];
  longint mon_e;
  int n_cmp = 0, n_err = 0, done_cnt = 0, d0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rstn) begin
      chk("ready_pair_equal", o_ipix_ready, o_wpix_ready);
      if (o_done) begin
        done_cnt++;
        chk("done_after_psums_taken", exp_q.size(), 0);
      end
      if (o_psum_valid && !i_psum_ready) chk("ready_low_under_backpressure", o_ipix_ready, 0);
      if (o_psum_valid && i_psum_ready && !i_cont_stall) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_psum: got %0d expected none", $signed(o_psum_data));
        end else begin
          mon_e = exp_q.pop_front();
          chk("psum", $signed(o_psum_data), mon_e);
        end
      end
    end
  end

  task automatic send(input logic signed [DWd-1:0] a, input logic signed [DWd-1:0] b,
                      input logic za = 1'b0, input logic zb = 1'b0);
    i_ipix_data = a; i_wpix_data = b; i_ipix_zero = za; i_wpix_zero = zb;
    i_ipix_valid = 1'b1; i_wpix_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge i_clk);
      if (o_ipix_ready) begin
        @(posedge i_clk); #1;
        return;
      end
    end
    n_cmp++; n_err++;
    $display("FAIL send_timeout: got no ready expected ready within 200 cycles");
  endtask

  task automatic idle();
    i_ipix_valid = 1'b0; i_wpix_valid = 1'b0; i_ipix_zero = 1'b0; i_wpix_zero = 1'b0;
  endtask

  task automatic start(input logic [ConfDWd-1:0] len);
    i_cfg_acclen = len; i_cont_start = 1'b1;
    @(posedge i_clk); #1;
    i_cont_start = 1'b0;
  endtask

  task automatic end_pass();
    bit seen;
    seen = 1'b0;
    i_cont_done = 1'b1;
    @(posedge i_clk); #1;
    i_cont_done = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge i_clk);
      if (o_done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no o_done expected pulse within 100 cycles");
    end
    @(posedge i_clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    chk("rst_psum_valid", o_psum_valid, 0);
    chk("rst_psum_data", o_psum_data, 0);
    chk("rst_skip", o_skip_cnt, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ready", o_ipix_ready, 0);
    @(posedge i_clk); #1;

    // basic group with latency check
    start(4'd3);
    exp_q.push_back(-7);
    send(2, 3); send(-4, 5); send(7, 1); idle();
    @(negedge i_clk); chk("lat_t0", o_psum_valid, 0);
    @(negedge i_clk); chk("lat_t1", o_psum_valid, 0);
    @(negedge i_clk); chk("lat_t2", o_psum_valid, 1);
    @(posedge i_clk); #1;
    end_pass();
    chk("skip_t1", o_skip_cnt, 0);

    // zero skip, multiplier operands held
    start(4'd2);
    exp_q.push_back(-6);
    send(5, 9, 1'b1, 1'b0);
    chk("op_a_gated", dut.op_a_q, 7);
    chk("op_b_gated", dut.op_b_q, 1);
    send(3, -2); idle();
    end_pass();
    chk("skip_t2", o_skip_cnt, 1);

    // acclen 0 = 16, max magnitude
    start(4'd0);
    exp_q.push_back(64'sd17178820624);
    for (int k = 0; k < 16; k++) send(32767, 32767);
    idle();
    end_pass();
    chk("skip_t3", o_skip_cnt, 0);

    // acclen 1 streaming with backpressure
    start(4'd1);
    for (int k = 1; k <= 6; k++) exp_q.push_back(k * k);
    fork
      begin
        for (int k = 1; k <= 6; k++) send(16'(k), 16'(k));
        idle();
      end
      begin
        repeat (3) @(posedge i_clk); #1 i_psum_ready = 1'b0;
        repeat (3) @(posedge i_clk); #1 i_psum_ready = 1'b1;
      end
    join
    end_pass();
    chk("t4_all_popped", exp_q.size(), 0);

    // short psum on drain
    start(4'd4);
    exp_q.push_back(5);
    send(1, 1); send(2, 2); idle();
    d0 = done_cnt;
    end_pass();
    repeat (5) @(posedge i_clk); #1;
    chk("t5_done_once", done_cnt - d0, 1);
    chk("t5_state_idle", int'(dut.state_q), 0);
    chk("t5_psum_idle", o_psum_valid, 0);

    // soft reset mid-group with held psum and stall
    start(4'd2);
    i_psum_ready = 1'b0;
    send(3, 3); send(1, 1); send(5, 5); idle();
    repeat (3) @(posedge i_clk); #1;
    chk("t6_held_valid", o_psum_valid, 1);
    i_cont_stall = 1'b1; i_cont_reset = 1'b1;
    @(posedge i_clk); #1;
    i_cont_stall = 1'b0; i_cont_reset = 1'b0; i_psum_ready = 1'b1;
    chk("t6_valid", o_psum_valid, 0);
    chk("t6_data", o_psum_data, 0);
    chk("t6_skip", o_skip_cnt, 0);
    chk("t6_done", o_done, 0);
    chk("t6_ready", o_ipix_ready, 0);
    chk("t6_state", int'(dut.state_q), 0);
    start(4'd2);
    exp_q.push_back(14);
    send(4, 5); send(6, -1); idle();
    end_pass();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200us");
    $fatal(1);
  end
endmodule
